// File: rtl/ram_sync_ctrl.sv
// Synchronous single-port data memory with a pipelined read path and a
// sequential clear engine that zeroes the array after reset or on command.
module ram_sync_ctrl #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 12,
  parameter int RD_LAT     = 1,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
  localparam logic [0:0] ST_RESET = INIT_CLEAR ? ST_CLEAR : ST_IDLE;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        r_state;
  logic [0:0]        w_stateNext;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cntNext;
  logic              r_busy;
  logic              r_drop;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_inIdle;
  logic              w_wrAccept;
  logic              w_rdAccept;
  logic              w_dropReq;
  logic              w_memWe;
  logic [ADDR_W-1:0] w_memAddr;
  logic [DATA_W-1:0] w_memData;
  logic              w_lastV;
  logic [DATA_W-1:0] w_lastD;

  // A clear request in IDLE takes priority over any access in the same cycle.
  assign w_inIdle   = (r_state == ST_IDLE);
  assign w_wrAccept = w_inIdle & ~clear & cs & we;
  assign w_rdAccept = w_inIdle & ~clear & cs & ~we;
  assign w_dropReq  = cs & ~(w_wrAccept | w_rdAccept);

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    if (!w_inIdle) begin
      if (r_cnt == LAST_ADDR) begin
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
      end else begin
        w_cntNext = r_cnt + 1'b1;
      end
    end else if (clear) begin
      w_stateNext = ST_CLEAR;
      w_cntNext   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_busy  <= INIT_CLEAR;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_busy  <= (w_stateNext == ST_CLEAR);
      r_drop  <= w_dropReq;
    end
  end

  // The single write port is shared between the sweep and user writes.
  assign w_memWe   = ~w_inIdle | w_wrAccept;
  assign w_memAddr = w_inIdle ? addr : r_cnt;
  assign w_memData = w_inIdle ? wdata : '0;

  always_ff @(posedge clock) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  generate
    if (RD_LAT == 1) begin : gNoPipe
      assign w_lastV = w_rdAccept;
      assign w_lastD = r_mem[addr];
    end else begin : gPipe
      logic [RD_LAT-2:0] r_vPipe;
      logic [DATA_W-1:0] r_dPipe [RD_LAT-1];

      // Data is captured at accept so later writes or a sweep cannot alter it.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_vPipe <= '0;
          for (int i = 0; i < RD_LAT-1; i++) begin
            r_dPipe[i] <= '0;
          end
        end else begin
          r_vPipe[0] <= w_rdAccept;
          r_dPipe[0] <= r_mem[addr];
          for (int i = 1; i < RD_LAT-1; i++) begin
            r_vPipe[i] <= r_vPipe[i-1];
            r_dPipe[i] <= r_dPipe[i-1];
          end
        end
      end

      assign w_lastV = r_vPipe[RD_LAT-2];
      assign w_lastD = r_dPipe[RD_LAT-2];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_lastV;
      if (w_lastV) begin
        r_rdata <= w_lastD;
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;
  assign drop   = r_drop;

endmodule

// File: tb/tb_ram_sync_ctrl.sv
// Bench for ram_sync_ctrl: two instances (read latency 1 and 3) share one
// stimulus stream; expected read data is queued at accept and popped on rvalid.
module tb_ram_sync_ctrl;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          cs;
  logic          we;
  logic          clear;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rdataA, rdataB;
  logic          rvalidA, rvalidB;
  logic          busyA, busyB;
  logic          dropA, dropB;

  always #5 clock = ~clock;

  ram_sync_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT_A), .INIT_CLEAR(1'b1)) dutA (
    .clock(clock), .reset(reset), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .clear(clear), .rdata(rdataA), .rvalid(rvalidA), .busy(busyA), .drop(dropA)
  );

  ram_sync_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT_B), .INIT_CLEAR(1'b1)) dutB (
    .clock(clock), .reset(reset), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .clear(clear), .rdata(rdataB), .rvalid(rvalidB), .busy(busyB), .drop(dropB)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rdExp_t;

  rdExp_t        qA[$];
  rdExp_t        qB[$];
  logic [DW-1:0] mMem [DEPTH];
  logic          mIdle;
  int            mCnt;
  logic          expBusy;
  logic          expDrop;
  logic [DW-1:0] lastA;
  logic [DW-1:0] lastB;
  int            cyc = 0;
  int            compared = 0;
  int            mismatched = 0;

  task automatic cmpBit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic cmpData(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Pops responses that are due this cycle and checks every output of both DUTs.
  task automatic checkOutput();
    logic   eA;
    logic   eB;
    rdExp_t item;
    eA = 1'b0;
    eB = 1'b0;
    if (qA.size() > 0 && qA[0].due == cyc) begin
      item  = qA.pop_front();
      lastA = item.data;
      eA    = 1'b1;
    end
    if (qB.size() > 0 && qB[0].due == cyc) begin
      item  = qB.pop_front();
      lastB = item.data;
      eB    = 1'b1;
    end
    cmpBit("rvalidA", rvalidA, eA);
    cmpData("rdataA", rdataA, lastA);
    cmpBit("rvalidB", rvalidB, eB);
    cmpData("rdataB", rdataB, lastB);
    cmpBit("busyA", busyA, expBusy);
    cmpBit("busyB", busyB, expBusy);
    cmpBit("dropA", dropA, expDrop);
    cmpBit("dropB", dropB, expDrop);
  endtask

  // Behavioural reference for one rising edge with the given sampled inputs.
  task automatic modelEdge(input logic c, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic clr);
    rdExp_t item;
    expDrop = 1'b0;
    if (!mIdle) begin
      mMem[mCnt] = '0;
      expDrop    = c;
      if (mCnt == DEPTH-1) begin
        mIdle = 1'b1;
        mCnt  = 0;
      end else begin
        mCnt++;
      end
    end else if (clr) begin
      mIdle   = 1'b0;
      mCnt    = 0;
      expDrop = c;
    end else if (c && w) begin
      mMem[a] = d;
    end else if (c) begin
      item.data = mMem[a];
      item.due  = cyc + LAT_A - 1;
      qA.push_back(item);
      item.due  = cyc + LAT_B - 1;
      qB.push_back(item);
    end
    expBusy = ~mIdle;
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic clr);
    cs    = c;
    we    = w;
    addr  = a;
    wdata = d;
    clear = clr;
    @(posedge clock);
    cyc++;
    modelEdge(c, w, a, d, clr);
    @(negedge clock);
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic doReset(input int holdCycles);
    cs    = 1'b0;
    we    = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    #1;
    qA.delete();
    qB.delete();
    lastA   = '0;
    lastB   = '0;
    mIdle   = 1'b0;
    mCnt    = 0;
    expBusy = 1'b1;
    expDrop = 1'b0;
    checkOutput();
    repeat (holdCycles) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cs    = 1'b0;
    we    = 1'b0;
    clear = 1'b0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
    @(negedge clock);
    $display("[TB] reset and initial sweep");
    doReset(2);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 5)      applyStimulus(1'b1, 1'b0, 4'h3, 4'h0, 1'b0);
      else if (i == 9) applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
      else             applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    end
    idleCycles(1);

    $display("[TB] read back cleared array");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 4'(i), 4'h0, 1'b0);
    idleCycles(LAT_B);

    $display("[TB] write then read next cycle");
    applyStimulus(1'b1, 1'b1, 4'h3, 4'hA, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h3, 4'h0, 1'b0);
    idleCycles(LAT_B);

    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 1'b1, 4'h5, 4'h1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h6, 4'h2, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h7, 4'h3, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h6, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h7, 4'h0, 1'b0);
    idleCycles(LAT_B + 1);

    $display("[TB] clear with colliding write, read in flight");
    applyStimulus(1'b1, 1'b0, 4'h7, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h2, 4'hF, 1'b1);
    idleCycles(DEPTH);
    applyStimulus(1'b1, 1'b0, 4'h2, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h7, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h3, 4'h0, 1'b0);
    idleCycles(LAT_B);

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(1'b1, 1'b1, 4'hC, 4'h9, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    idleCycles(7);
    doReset(2);
    idleCycles(DEPTH + 1);

    $display("[TB] reset with a read in flight");
    applyStimulus(1'b1, 1'b1, 4'h9, 4'h5, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h9, 4'h0, 1'b0);
    doReset(3);
    idleCycles(DEPTH + 1);
    applyStimulus(1'b1, 1'b0, 4'h9, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'hC, 4'h0, 1'b0);
    idleCycles(LAT_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_sync_ctrl.md
Name: ram_sync_ctrl

Overview:
Parametrised synchronous single-port data memory for the processor datapath. It replaces the asynchronous chip-select/read-write RAM with a clocked request interface and a pipelined read latency, and splits the data bus into separate write and read buses. A sequential clear engine zeroes the whole array after reset or on command, and a `busy` flag and a `drop` pulse report it to the control unit.

Parameters:
DATA_W, 4, data word width in bits (1..32)
ADDR_W, 12, address width; depth DEPTH = 2**ADDR_W words
RD_LAT, 1, read latency in clock cycles from accept to rvalid (1..4)
INIT_CLEAR, 1, 1 = run clear sweep automatically after reset; 0 = enter IDLE directly

Ports:
clock   in   1       rising-edge clock
reset   in   1       asynchronous, active-high reset
cs      in   1       access request (chip select), sampled at rising edge
we      in   1       1 = write, 0 = read; valid when cs=1
addr    in   ADDR_W  word address
wdata   in   DATA_W  write data
clear   in   1       start clear sweep (level, sampled in IDLE)
rdata   out  DATA_W  read data, valid when rvalid=1; holds last value otherwise
rvalid  out  1       one-cycle pulse per accepted read
busy    out  1       1 while clear sweep in progress
drop    out  1       one-cycle pulse: request arrived while busy and was ignored

Behaviour:
- Reset (async, active-high): rdata=0, rvalid=0, drop=0, read pipeline flushed, sweep counter=0. State=CLEAR if INIT_CLEAR=1, else IDLE. busy=INIT_CLEAR while reset is asserted and after release. Array contents are not touched by reset itself.
- States: CLEAR, IDLE.
- CLEAR: each cycle write 0 to mem[cnt] and increment cnt. The sweep takes exactly DEPTH cycles. When cnt=DEPTH-1 is written, the next state is IDLE and cnt returns to 0. busy=1 throughout and falls on the first IDLE cycle. `clear` is ignored in CLEAR and does not restart the sweep.
- CLEAR with cs=1: the request is not performed and drop=1 on the next cycle. This applies to reads and writes alike.
- IDLE with clear=1: next state CLEAR, cnt=0. If cs=1 in the same cycle, clear wins: the access is dropped and drop pulses.
- IDLE write (cs=1, we=1): mem[addr] <= wdata at that edge. No response is generated.
- IDLE read (cs=1, we=0): data is read at accept, then rvalid=1 with rdata=mem[addr] exactly RD_LAT cycles after the accepting edge.
  - Fully pipelined: one read accepted per cycle, responses return in order, back-to-back reads give back-to-back rvalid.
  - Write to A at cycle n, read of A at cycle n+1: returns the new data.
  - A read accepted before clear starts completes normally with pre-clear data.
- Address arithmetic is modulo DEPTH. Sweep counter width is ADDR_W+1 or end-detected; no overflow is permitted.
- A reset asserted mid-sweep or mid-read aborts the operation immediately. No rvalid is produced for in-flight reads. After release the state restarts per INIT_CLEAR.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset with INIT_CLEAR=1, ADDR_W=4 -> busy=1 for 16 cycles after release, then 0. Reading addresses 0..15 returns 0 each, with rvalid RD_LAT cycles after each accept.
- IDLE, DATA_W=4: write 4'hA to 12'h123, then read 12'h123 the next cycle -> rvalid with rdata=4'hA. Repeat with RD_LAT=3 -> rvalid arrives exactly 3 cycles after the read.
- Back-to-back reads of addresses 5, 6, 7 holding 1, 2, 3 -> three consecutive rvalid pulses with rdata 1, 2, 3 in order. rdata holds 3 afterwards.
- Pulse clear in IDLE together with a write of 4'hF to address 2 -> write suppressed, drop=1, busy=1 for DEPTH cycles. Reading address 2 afterwards returns 0.
- cs=1 read issued on cycle 5 of a sweep -> no rvalid and drop=1 one cycle later. clear re-pulsed mid-sweep -> busy still falls at the original end cycle.
- Assert reset during sweep cycle 7 and during an in-flight read with RD_LAT=2 -> no rvalid; rdata=0, busy=1. The sweep restarts from 0 and takes the full DEPTH cycles.
